// File: rtl/mpdmac_cfg_if.sv
// rtl/mpdmac_cfg_if.sv - APB3 register bus bundle for the mpdmac configuration block
// Signals: psel_i, penable_i, paddr_i[11:0], pwrite_i, pwdata_i[31:0] (master to slave);
//          prdata_o[31:0], pready_o, pslverr_o (slave to master).
interface mpdmac_cfg_if;
    logic        psel_i;
    logic        penable_i;
    logic [11:0] paddr_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );

    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/mpdmac_cfg.sv
// rtl/mpdmac_cfg.sv - APB3 configuration/status register block for the matrix DMA engine
// Ports: clk, rst_n (async, active-low); apb (mpdmac_cfg_if.slave, zero-wait-state APB3);
//        src_addr_o/dst_addr_o/mat_width_o engine setup; start_o one-cycle start pulse;
//        done_i engine idle level; irq_o completion interrupt.
module mpdmac_cfg #(
    parameter logic [31:0] VERSION = 32'h0001_2024
) (
    input  logic               clk,
    input  logic               rst_n,
    mpdmac_cfg_if.slave        apb,
    output logic [31:0]        src_addr_o,
    output logic [31:0]        dst_addr_o,
    output logic [5:0]         mat_width_o,
    output logic               start_o,
    input  logic               done_i,
    output logic               irq_o
);
    // Word offsets (paddr_i[11:2])
    localparam logic [9:0] A_VERSION = 10'h000;
    localparam logic [9:0] A_SRC     = 10'h040;
    localparam logic [9:0] A_DST     = 10'h041;
    localparam logic [9:0] A_MW      = 10'h042;
    localparam logic [9:0] A_START   = 10'h043;
    localparam logic [9:0] A_STATUS  = 10'h044;
    localparam logic [9:0] A_INTEN   = 10'h045;
    localparam logic [9:0] A_INTST   = 10'h046;
    localparam logic [9:0] A_CNT     = 10'h047;

    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [5:0]  mat_width;
    logic        int_en;
    logic        int_status;
    logic [31:0] cycle_cnt;
    logic        start_q;
    logic        done_q;

    logic        access;
    logic        wr;
    logic        rd;
    logic [9:0]  word;
    logic        mapped;
    logic [31:0] rdata;
    logic        start_req;
    logic        start_ok;
    logic        done_rise;
    logic        unused_addr_bits;

    // Gating with rst_n keeps the combinational bus outputs quiet while in reset.
    assign access = apb.psel_i & apb.penable_i & rst_n;
    assign wr     = access & apb.pwrite_i;
    assign rd     = access & ~apb.pwrite_i;
    assign word   = apb.paddr_i[11:2];
    assign unused_addr_bits = &{1'b0, apb.paddr_i[1:0]};

    always_comb begin
        rdata  = 32'h0;
        mapped = 1'b1;
        case (word)
            A_VERSION: rdata = VERSION;
            A_SRC:     rdata = src_addr;
            A_DST:     rdata = dst_addr;
            A_MW:      rdata = {26'h0, mat_width};
            A_START:   rdata = 32'h0;
            A_STATUS:  rdata = {31'h0, done_i};
            A_INTEN:   rdata = {31'h0, int_en};
            A_INTST:   rdata = {31'h0, int_status};
            A_CNT:     rdata = cycle_cnt;
            default:   mapped = 1'b0;
        endcase
    end

    // The engine only supports even widths in 2..60 and must be idle to accept work.
    assign start_ok  = done_i & ~mat_width[0] & (mat_width >= 6'd2) & (mat_width <= 6'd60);
    assign start_req = wr & (word == A_START) & apb.pwdata_i[0];
    assign done_rise = done_i & ~done_q;

    assign apb.pready_o  = 1'b1;
    assign apb.pslverr_o = access & (~mapped | (start_req & ~start_ok));
    assign apb.prdata_o  = rd ? rdata : 32'h0;

    assign src_addr_o  = src_addr;
    assign dst_addr_o  = dst_addr;
    assign mat_width_o = mat_width;
    assign start_o     = start_q;
    assign irq_o       = int_en & int_status;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_addr   <= 32'h0;
            dst_addr   <= 32'h0;
            mat_width  <= 6'h0;
            int_en     <= 1'b0;
            int_status <= 1'b0;
            cycle_cnt  <= 32'h0;
            start_q    <= 1'b0;
            done_q     <= 1'b1;
        end else begin
            start_q <= start_req & start_ok;
            done_q  <= done_i;

            if (wr) begin
                case (word)
                    A_SRC:   src_addr  <= apb.pwdata_i;
                    A_DST:   dst_addr  <= apb.pwdata_i;
                    A_MW:    mat_width <= apb.pwdata_i[5:0];
                    A_INTEN: int_en    <= apb.pwdata_i[0];
                    default: ;
                endcase
            end

            // A completion landing in the same cycle as a clear must not be lost.
            if (done_rise) begin
                int_status <= 1'b1;
            end else if (wr && (word == A_INTST) && apb.pwdata_i[0]) begin
                int_status <= 1'b0;
            end

            if (start_q) begin
                cycle_cnt <= 32'h0;
            end else if (!done_i && (cycle_cnt != 32'hFFFF_FFFF)) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_mpdmac_cfg.sv
// tb/tb_mpdmac_cfg.sv - self-checking bench for mpdmac_cfg
module tb_mpdmac_cfg;
    localparam logic [31:0] VER = 32'h0001_2024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        done_i = 1'b1;
    logic [31:0] src_addr_o;
    logic [31:0] dst_addr_o;
    logic [5:0]  mat_width_o;
    logic        start_o;
    logic        irq_o;

    mpdmac_cfg_if bus ();

    mpdmac_cfg #(.VERSION(VER)) dut (
        .clk(clk), .rst_n(rst_n), .apb(bus),
        .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .mat_width_o(mat_width_o),
        .start_o(start_o), .done_i(done_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic setup_err_seen = 1'b0;

    // Reference model state
    logic [31:0] m_src, m_dst, m_cnt;
    logic [5:0]  m_mw;
    logic        m_en, m_ist;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_mapped(input logic [11:0] a);
        logic [11:0] off;
        off = {a[11:2], 2'b00};
        return (off == 12'h000) || (off >= 12'h100 && off <= 12'h11C);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [11:0] off;
        off = {a[11:2], 2'b00};
        case (off)
            12'h000: return VER;
            12'h100: return m_src;
            12'h104: return m_dst;
            12'h108: return {26'h0, m_mw};
            12'h110: return {31'h0, done_i};
            12'h114: return {31'h0, m_en};
            12'h118: return {31'h0, m_ist};
            12'h11C: return m_cnt;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_start_ok();
        int w;
        w = m_mw;
        return done_i && (w % 2 == 0) && w >= 2 && w <= 60;
    endfunction

    task automatic model_reset();
        m_src = 0; m_dst = 0; m_cnt = 0; m_mw = 0; m_en = 0; m_ist = 0;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
        @(posedge clk); #1;
        bus.psel_i = 1; bus.penable_i = 0; bus.pwrite_i = 1; bus.paddr_i = a; bus.pwdata_i = d;
        @(negedge clk); setup_err_seen |= bus.pslverr_o;
        @(posedge clk); #1; bus.penable_i = 1;
        @(negedge clk); err = bus.pslverr_o;
        @(posedge clk); #1; bus.psel_i = 0; bus.penable_i = 0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        @(posedge clk); #1;
        bus.psel_i = 1; bus.penable_i = 0; bus.pwrite_i = 0; bus.paddr_i = a;
        @(negedge clk); setup_err_seen |= bus.pslverr_o;
        @(posedge clk); #1; bus.penable_i = 1;
        @(negedge clk); d = bus.prdata_o; err = bus.pslverr_o;
        @(posedge clk); #1; bus.psel_i = 0; bus.penable_i = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst_n = 0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1;
        model_reset();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_src"}, src_addr_o, m_src);
        chk({tag, "_dst"}, dst_addr_o, m_dst);
        chk({tag, "_mw"}, {26'h0, mat_width_o}, {26'h0, m_mw});
    endtask

    initial begin
        logic [31:0] rdv;
        logic        err;
        logic [11:0] addr;
        logic [31:0] data;
        logic [11:0] offs [10];
        bit          exp_err, exp_start;
        int          n_low;

        offs = '{12'h000, 12'h100, 12'h104, 12'h108, 12'h10C, 12'h110,
                 12'h114, 12'h118, 12'h11C, 12'h200};
        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0; bus.paddr_i = 0; bus.pwdata_i = 0;
        model_reset();

        // Reset state, with a read access held on the bus during reset
        bus.psel_i = 1; bus.penable_i = 1; bus.paddr_i = 12'h000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_prdata", bus.prdata_o, 32'h0);
        chk("rst_pslverr", {31'h0, bus.pslverr_o}, 32'h0);
        chk("rst_start", {31'h0, start_o}, 32'h0);
        chk("rst_irq", {31'h0, irq_o}, 32'h0);
        check_outputs("rst");
        bus.psel_i = 0; bus.penable_i = 0;
        #1; rst_n = 1;

        // Scenario 1
        apb_read(12'h000, rdv, err);
        chk("s1_version", rdv, VER);
        chk("s1_version_err", {31'h0, err}, 32'h0);
        apb_read(12'h100, rdv, err);
        chk("s1_src", rdv, 32'h0);
        for (int i = 1; i < 9; i++) begin
            apb_read(offs[i], rdv, err);
            chk($sformatf("s1_reg_%03h", offs[i]), rdv, m_read(offs[i]));
        end
        chk("s1_irq", {31'h0, irq_o}, 32'h0);

        // Randomized register traffic against the model (done_i held high)
        for (int i = 0; i < 80; i++) begin
            addr = offs[$urandom_range(0, 9)] | 12'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                if ({addr[11:2], 2'b00} == 12'h108) data[5:0] = 6'($urandom_range(0, 63));
                exp_err = !m_mapped(addr) ||
                          ({addr[11:2], 2'b00} == 12'h10C && data[0] && !m_start_ok());
                exp_start = ({addr[11:2], 2'b00} == 12'h10C) && data[0] && m_start_ok();
                apb_write(addr, data, err);
                chk($sformatf("rnd_wr_err_%03h", addr), {31'h0, err}, {31'h0, exp_err});
                chk("rnd_wr_start", {31'h0, start_o}, {31'h0, exp_start});
                case ({addr[11:2], 2'b00})
                    12'h100: m_src = data;
                    12'h104: m_dst = data;
                    12'h108: m_mw = data[5:0];
                    12'h114: m_en = data[0];
                    12'h118: if (data[0]) m_ist = 0;
                    default: ;
                endcase
                if (exp_start) m_cnt = 0;
            end else begin
                apb_read(addr, rdv, err);
                chk($sformatf("rnd_rd_%03h", addr), rdv, m_read(addr));
                chk("rnd_rd_err", {31'h0, err}, {31'h0, !m_mapped(addr)});
            end
            check_outputs("rnd");
            chk("rnd_irq", {31'h0, irq_o}, {31'h0, m_en & m_ist});
        end

        // Scenario 2
        apb_write(12'h100, 32'h1000, err); m_src = 32'h1000;
        apb_write(12'h104, 32'h2000, err); m_dst = 32'h2000;
        apb_write(12'h108, 32'h4, err);    m_mw = 6'd4;
        check_outputs("s2");
        apb_write(12'h10C, 32'h1, err);
        chk("s2_start_err", {31'h0, err}, 32'h0);
        chk("s2_start_hi", {31'h0, start_o}, 32'h1);
        @(posedge clk); #1;
        chk("s2_start_lo", {31'h0, start_o}, 32'h0);
        apb_write(12'h10C, 32'h0, err);
        chk("s2_start0_err", {31'h0, err}, 32'h0);
        chk("s2_start0_nostart", {31'h0, start_o}, 32'h0);

        // Scenario 3
        apb_write(12'h108, 32'h5, err);
        apb_write(12'h10C, 32'h1, err);
        chk("s3_w5_err", {31'h0, err}, 32'h1);
        chk("s3_w5_start", {31'h0, start_o}, 32'h0);
        apb_write(12'h108, 32'h0, err);
        apb_write(12'h10C, 32'h1, err);
        chk("s3_w0_err", {31'h0, err}, 32'h1);
        chk("s3_w0_start", {31'h0, start_o}, 32'h0);
        apb_write(12'h108, 32'h4, err);
        done_i = 0;
        apb_write(12'h10C, 32'h1, err);
        chk("s3_busy_err", {31'h0, err}, 32'h1);
        chk("s3_busy_start", {31'h0, start_o}, 32'h0);
        @(posedge clk); #1;
        chk("s3_busy_start2", {31'h0, start_o}, 32'h0);
        done_i = 1;
        do_reset();

        // Scenario 4: first run 10 cycles busy, then a random busy length
        apb_write(12'h114, 32'h1, err); m_en = 1;
        apb_write(12'h108, 32'h4, err); m_mw = 6'd4;
        for (int r = 0; r < 3; r++) begin
            n_low = (r == 0) ? 10 : $urandom_range(1, 50);
            apb_write(12'h10C, 32'h1, err);
            chk("s4_start", {31'h0, start_o}, 32'h1);
            @(posedge clk); #1; done_i = 0;
            repeat (n_low) @(posedge clk);
            #1; done_i = 1;
            apb_read(12'h11C, rdv, err);
            chk($sformatf("s4_cnt_%0d", n_low), rdv, 32'(n_low));
            apb_read(12'h118, rdv, err);
            chk("s4_intst", rdv, 32'h1);
            chk("s4_irq", {31'h0, irq_o}, 32'h1);
            apb_write(12'h118, 32'h1, err);
            chk("s4_irq_clr", {31'h0, irq_o}, 32'h0);
        end

        // Scenario 5: clear collides with a done rising edge
        apb_read(12'h118, rdv, err);
        chk("s5_pre", rdv, 32'h0);
        @(posedge clk); #1; done_i = 0;
        repeat (3) @(posedge clk);
        #1;
        bus.psel_i = 1; bus.penable_i = 0; bus.pwrite_i = 1; bus.paddr_i = 12'h118; bus.pwdata_i = 32'h1;
        @(posedge clk); #1; bus.penable_i = 1; done_i = 1;
        @(posedge clk); #1; bus.psel_i = 0; bus.penable_i = 0;
        apb_read(12'h118, rdv, err);
        chk("s5_intst_kept", rdv, 32'h1);
        chk("s5_irq", {31'h0, irq_o}, 32'h1);
        m_ist = 1;
        apb_read(12'h11C, rdv, err);
        m_cnt = rdv;

        // Scenario 6: unmapped offset
        apb_read(12'h200, rdv, err);
        chk("s6_rd_data", rdv, 32'h0);
        chk("s6_rd_err", {31'h0, err}, 32'h1);
        apb_write(12'h200, 32'hFFFF_FFFF, err);
        chk("s6_wr_err", {31'h0, err}, 32'h1);
        for (int i = 0; i < 9; i++) begin
            apb_read(offs[i], rdv, err);
            chk($sformatf("s6_keep_%03h", offs[i]), rdv, m_read(offs[i]));
        end
        chk("setup_phase_err", {31'h0, setup_err_seen}, 32'h0);

        // Reset asserted while start_o is high
        apb_write(12'h10C, 32'h1, err);
        chk("rs_start_hi", {31'h0, start_o}, 32'h1);
        rst_n = 0;
        #1;
        chk("rs_start_lo", {31'h0, start_o}, 32'h0);
        chk("rs_irq", {31'h0, irq_o}, 32'h0);
        model_reset();
        check_outputs("rs");
        @(posedge clk); #1; rst_n = 1;
        @(posedge clk); #1;
        chk("rs_no_pending", {31'h0, start_o}, 32'h0);
        apb_read(12'h118, rdv, err);
        chk("rs_intst", rdv, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mpdmac_cfg.md
MPDMAC_CFG -- requirements
Module: mpdmac_cfg

Interface
REQ-001 SHALL have parameter VERSION, default 32'h0001_2024, value returned by the VERSION register.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have APB3 slave ports:
- psel_i  input  1  select.
- penable_i  input  1  access phase.
- paddr_i  input  12  byte address.
- pwrite_i  input  1  1 = write.
- pwdata_i  input  32  write data.
- prdata_o  output  32  read data.
- pready_o  output  1  ready.
- pslverr_o  output  1  error.
REQ-005 SHALL have engine-side ports:
- src_addr_o  output  32  source base.
- dst_addr_o  output  32  destination base.
- mat_width_o  output  6  matrix width.
- start_o  output  1  start pulse.
- done_i  input  1  engine idle/done level.
- irq_o  output  1  interrupt.

Function
REQ-006 SHALL tie pready_o to 1: every access completes in a single access phase (psel_i & penable_i), with zero wait states.
REQ-007 SHALL decode the following register map. Unmapped offsets SHALL read 0 and SHALL raise pslverr_o in the access phase.
- 0x000 VERSION: RO.
- 0x100 SRC_ADDR: RW, 32 bits.
- 0x104 DST_ADDR: RW, 32 bits.
- 0x108 MAT_WIDTH: RW, bits [5:0]; upper bits read 0.
- 0x10C START: WO, reads 0.
- 0x110 STATUS: RO, bit0 = done_i.
- 0x114 INT_EN: RW, bit0.
- 0x118 INT_STATUS: W1C, bit0.
- 0x11C CYCLE_CNT: RO, 32 bits.
REQ-008 SHALL drive prdata_o combinationally from register state during a read access phase, and 0 otherwise. A write to a RO offset SHALL be ignored with pslverr_o=0.
REQ-009 SHALL drive src_addr_o, dst_addr_o and mat_width_o directly from their registers, updated the cycle after the write access phase.
REQ-010 SHALL treat a write to START with pwdata_i[0]=1 as a start request.
- The request SHALL be accepted only if done_i=1, MAT_WIDTH is even, and 2 <= MAT_WIDTH <= 60.
- Otherwise pslverr_o=1 and no start is issued.
- Writing pwdata_i[0]=0 SHALL do nothing and return no error.
REQ-011 SHALL assert start_o for exactly one cycle, the cycle after an accepted START access phase; start_o SHALL be registered.
REQ-012 SHALL keep a registered copy done_q of done_i and detect the rising edge as done_i & ~done_q.
REQ-013 SHALL set INT_STATUS bit0 on a done rising edge. A W1C write with pwdata_i[0]=1 SHALL clear it. If set and clear occur in the same cycle, set SHALL win.
REQ-014 SHALL drive irq_o = INT_EN[0] & INT_STATUS[0], combinational from registers.
REQ-015 SHALL clear CYCLE_CNT to 0 on the cycle start_o is asserted.
- It SHALL increment by 1 every cycle in which done_i=0.
- It SHALL saturate at 32'hFFFF_FFFF.
- It SHALL hold its value while done_i=1.
REQ-016 SHALL use only paddr_i[11:2] for decode; paddr_i[1:0] are ignored.
REQ-017 SHALL ignore psel_i & ~penable_i (setup phase): no register changes and pslverr_o=0.

Reset
REQ-018 SHALL, while rst_n=0, hold the following values:
- SRC_ADDR, DST_ADDR, MAT_WIDTH, INT_EN, INT_STATUS, CYCLE_CNT = 0.
- start_o = 0.
- done_q = 1, so a done_i already high after reset causes no interrupt.
- prdata_o = 0, pslverr_o = 0, irq_o = 0.
REQ-019 SHALL, on reset assertion during any access or while start_o is high, return immediately to the REQ-018 values with no pending start retained.

Verification
REQ-020 Scenario 1: reset, then read 0x000, then read 0x100.
- Required: prdata_o = 32'h0001_2024, then 0.
- All register fields = 0; irq_o = 0.
REQ-021 Scenario 2: write SRC=0x1000, DST=0x2000, MAT_WIDTH=4, then START=1 with done_i=1.
- Required: outputs 0x1000/0x2000/4.
- start_o high for exactly 1 cycle, the cycle after the access phase.
- pslverr_o = 0.
REQ-022 Scenario 3: START with MAT_WIDTH=5, then with MAT_WIDTH=0, then with MAT_WIDTH=4 while done_i=0.
- Required: pslverr_o = 1 on each access.
- start_o never asserted.
REQ-023 Scenario 4: INT_EN=1, accepted start, done_i low for 10 cycles, then high.
- Required: CYCLE_CNT reads 10.
- INT_STATUS = 1; irq_o = 1.
- Write 0x118 = 1 gives irq_o = 0 next cycle.
REQ-024 Scenario 5: W1C write to 0x118 in the same cycle as a done_i rising edge.
- Required: INT_STATUS stays 1.
REQ-025 Scenario 6: access 0x200, both read and write.
- Required: pslverr_o = 1, prdata_o = 0, no register changes.
